conv_win_seq: RTL and testbench
===============================

Name: conv_win_seq

Overview:
- Parametrised successor to the convolution control unit. Generalises the fixed 3-row window to a KxK window over NM rotating row banks.
- Per output row, streams W+K-1 vertical columns (K pixels each) to the pixel unit, with zero or clamp padding on all four frame edges.
- Issues bank reads, backpressures on pu_ready, releases consumed banks, and flags frame completion.
- Sits between the memory unit (row banks) and the pixel unit.

Parameters:
XB, 10, column index width (cfg_width <= 2^XB-1)
YB, 10, row index width
PB, 8, pixel width
NM, 4, number of row banks; must be >= K+1
K, 3, filter size; odd, >= 3; H = (K-1)/2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
cfg_width  in  XB  frame width W, sampled on accepted start
cfg_height  in  YB  frame height Ht, sampled on accepted start
cfg_pad_mode  in  1  0 = zero pad, 1 = clamp/replicate edge; sampled on start
start  in  1  frame start request, accepted only in IDLE
mb_minfill  in  NM  bank b holds a complete row
pu_data  in  NM x PB  bank read data, valid 1 cycle after mb_rd_en
mb_rd_en  out  NM  per-bank read strobe
mb_rd_addr  out  XB  shared column read address
mem_release  out  NM  one-cycle mask of banks freed for refill
col_data  out  K x PB  window column; lane 0 = top row
col_valid  out  1  col_data valid
col_first  out  1  first column of an output row
col_last  out  1  last column of an output row
pu_ready  in  1  pixel unit accepts the column when col_valid && pu_ready
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the last column is accepted
cfg_err  out  1  one-cycle pulse when start is rejected for a bad config

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; all counters 0; output buffer empty. All outputs 0.
- Row mapping: source row s lives in bank s mod NM.
- Output row r, window lane j: source row s = r-H+j.
  - s < 0 or s > Ht-1: zero mode drives 0 on the lane and issues no read. Clamp mode uses row clamp(s, 0, Ht-1).
- Output column c ranges 0..W+2H-1. Source column x = c-H.
  - x out of range: zero mode drives 0; clamp mode reads address clamp(x, 0, W-1).
- Column counter is XB+1 bits wide.
- FSM: IDLE -> WAIT_ROW -> RUN -> (WAIT_ROW | DRAIN) -> DONE -> IDLE.
  - IDLE: on start, if W==0 or Ht==0, pulse cfg_err and stay in IDLE. Otherwise latch cfg, set r=0, go to WAIT_ROW.
  - WAIT_ROW: wait until mb_minfill is set for the bank of every in-range source row up to min(r+H, Ht-1). Then c=0, go to RUN.
  - RUN: issue one column per cycle when credit > 0.
    - credit = 2 - (buffer occupancy) - (reads in flight).
    - Issuing drives mb_rd_en for non-padded lanes and mb_rd_addr, and increments c.
    - After issuing c = W+2H-1: if r < Ht-1, go to WAIT_ROW with r+1; else go to DRAIN.
  - DRAIN: wait for the output buffer to empty, then go to DONE.
  - DONE: pulse frame_done for 1 cycle, go to IDLE.
- Datapath: 2-entry output FIFO (skid).
  - pu_data plus a per-lane pad flag, delayed 1 cycle, are written into the FIFO the cycle after the read.
  - Read issued in cycle t produces col_valid at t+2 at the earliest.
  - Sustains 1 column/cycle while pu_ready=1.
  - col_data, col_first and col_last are held stable while col_valid && !pu_ready.
- Release:
  - When the last column of row r is issued and r-H >= 0 and r < Ht-1: mem_release has the bit for bank (r-H) mod NM set.
  - At the end of the last row: mem_release sets the bits for all rows max(0, Ht-1-2H)..Ht-1 not already released, as a single-cycle mask.
- Boundary cases:
  - Ht < K: every lane outside the frame is padded; no out-of-range bank is waited on.
  - W=1: W+2H columns per row; col_first and col_last are on different columns.
  - start outside IDLE is ignored.
  - mb_minfill deasserting during RUN has no effect on the current row.
  - Reset mid-frame discards the FIFO and in-flight reads.
  - No mem_release is generated by reset.

Test Plan:
- Reset hold: rst=0 for 3 cycles with start=1 -> all outputs 0, busy=0.
- Basic frame: K=3, zero mode, W=4, Ht=3, pixel(row,col)=16*row+col, all minfill=1, pu_ready=1.
  - Expect 18 columns, one per cycle.
  - Row 0, column 1 = {0,0,16}.
  - Row 0, column 5 = {0,0,0}.
  - mem_release = 0001 after row 1; 0110 after row 2.
  - frame_done one cycle after the last accept.
- Clamp mode, same frame -> row 0, column 0 = {0,0,16}; row 2, column 5 = {19,35,35}.
- Backpressure: toggle pu_ready every cycle -> identical column sequence, no drops or duplicates, col_data stable while stalled.
- Minfill gating: bank 2 minfill held low -> block sits in WAIT_ROW for row 1 with no reads issued; it resumes 1 cycle after bank 2 minfill rises.
- Config error and mid-frame reset:
  - start with W=0 -> cfg_err pulse, busy=0.
  - rst=0 at column 7 of row 1 -> IDLE, col_valid=0 the next cycle.
  - A new start then replays from row 0.

Source files
------------

// File: rtl/conv_win_seq.sv
// rtl/conv_win_seq.sv - KxK convolution window sequencer over NM rotating row banks
module conv_win_seq #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8,
    parameter int NM = 4,
    parameter int K  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XB-1:0]     cfg_width,
    input  logic [YB-1:0]     cfg_height,
    input  logic              cfg_pad_mode,
    input  logic              start,
    input  logic [NM-1:0]     mb_minfill,
    input  logic [NM*PB-1:0]  pu_data,
    output logic [NM-1:0]     mb_rd_en,
    output logic [XB-1:0]     mb_rd_addr,
    output logic [NM-1:0]     mem_release,
    output logic [K*PB-1:0]   col_data,
    output logic              col_valid,
    output logic              col_first,
    output logic              col_last,
    input  logic              pu_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);
    localparam int H  = (K - 1) / 2;
    localparam int BW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = XB + 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_ROW, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [XB-1:0]   w_q;
    logic [YB-1:0]   ht_q;
    logic            pad_q;
    logic [YB-1:0]   row;
    logic [BW-1:0]   row_bank;
    logic [CW-1:0]   col;
    logic [CW-1:0]   col_end;

    logic [K-1:0]    lane_in;
    logic [K-1:0]    lane_pad;
    logic [BW-1:0]   lane_bank [K];
    logic            rows_ready;
    logic            col_in;
    logic [XB-1:0]   addr_c;
    logic            col_is_first;
    logic            col_is_last;
    logic            row_is_last;
    logic            cfg_bad;
    logic            issue;
    logic            pop;
    logic [2:0]      fill;
    logic [NM-1:0]   rel_nx;

    logic            v1;
    logic [K-1:0]    p1_pad;
    logic [BW-1:0]   p1_bank [K];
    logic            p1_first;
    logic            p1_last;
    logic [K*PB-1:0] din_data;

    logic [K*PB-1:0] e_data [2];
    logic [1:0]      e_first;
    logic [1:0]      e_last;
    logic [1:0]      occ;
    logic [1:0]      occ_base;

    // Bank holding row (current row + d); d is limited to [-H, H] so two folds suffice.
    function automatic logic [BW-1:0] bank_of(input logic [BW-1:0] base, input int d);
        int v;
        v = int'(base) + NM + d;
        if (v >= 2 * NM)
            v = v - 2 * NM;
        else if (v >= NM)
            v = v - NM;
        return v[BW-1:0];
    endfunction

    assign cfg_bad      = (cfg_width == '0) || (cfg_height == '0);
    assign col_end      = CW'(w_q) + CW'(2 * H - 1);
    assign col_is_first = (col == '0);
    assign col_is_last  = (col == col_end);
    assign row_is_last  = (row == ht_q - YB'(1));
    assign pop          = col_valid && pu_ready;
    // FIFO content at the end of this cycle, not counting a read issued now
    assign fill         = 3'(occ) + 3'(v1) - 3'(pop);
    assign issue        = (state == S_RUN) && (fill < 3'd2);

    always_comb begin
        int s;
        int d;
        int x;
        rows_ready = 1'b1;
        mb_rd_en   = '0;
        lane_in    = '0;
        lane_pad   = '0;
        x = int'(col) - H;
        col_in = (x >= 0) && (x < int'(w_q));
        if (x < 0)
            addr_c = '0;
        else if (x >= int'(w_q))
            addr_c = w_q - XB'(1);
        else
            addr_c = x[XB-1:0];
        for (int j = 0; j < K; j++) begin
            s = int'(row) + j - H;
            lane_in[j] = (s >= 0) && (s < int'(ht_q));
            // Clamped lanes resolve to the nearest edge row, still within [-H, H] of row
            if (s < 0)
                d = -int'(row);
            else if (s >= int'(ht_q))
                d = int'(ht_q) - 1 - int'(row);
            else
                d = j - H;
            lane_bank[j] = bank_of(row_bank, d);
            lane_pad[j]  = !pad_q && !(lane_in[j] && col_in);
            if (lane_in[j] && !mb_minfill[lane_bank[j]])
                rows_ready = 1'b0;
            if (issue && !lane_pad[j])
                mb_rd_en[lane_bank[j]] = 1'b1;
        end
        mb_rd_addr = issue ? addr_c : '0;
    end

    always_comb begin
        rel_nx = '0;
        if (issue && col_is_last) begin
            if (!row_is_last) begin
                if (int'(row) >= H)
                    rel_nx[bank_of(row_bank, -H)] = 1'b1;
            end else begin
                for (int j = 0; j <= H; j++)
                    if (int'(row) >= j)
                        rel_nx[bank_of(row_bank, -j)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        busy       = (state != S_IDLE);
        frame_done = 1'b0;
        case (state)
            S_IDLE:     if (start && !cfg_bad) state_nx = S_WAIT_ROW;
            S_WAIT_ROW: if (rows_ready) state_nx = S_RUN;
            S_RUN:      if (issue && col_is_last) state_nx = row_is_last ? S_DRAIN : S_WAIT_ROW;
            S_DRAIN:    if (fill == 3'd0) state_nx = S_DONE;
            S_DONE: begin
                frame_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_q         <= '0;
            ht_q        <= '0;
            pad_q       <= 1'b0;
            row         <= '0;
            row_bank    <= '0;
            col         <= '0;
            cfg_err     <= 1'b0;
            mem_release <= '0;
        end else begin
            cfg_err     <= (state == S_IDLE) && start && cfg_bad;
            mem_release <= rel_nx;
            if (state == S_IDLE && start && !cfg_bad) begin
                w_q      <= cfg_width;
                ht_q     <= cfg_height;
                pad_q    <= cfg_pad_mode;
                row      <= '0;
                row_bank <= '0;
            end
            if (state == S_WAIT_ROW && rows_ready)
                col <= '0;
            if (issue) begin
                col <= col + CW'(1);
                if (col_is_last && !row_is_last) begin
                    row      <= row + YB'(1);
                    row_bank <= (row_bank == BW'(NM - 1)) ? '0 : row_bank + BW'(1);
                end
            end
        end
    end

    always_comb begin
        din_data = '0;
        for (int j = 0; j < K; j++)
            din_data[j*PB +: PB] = p1_pad[j] ? '0 : pu_data[int'(p1_bank[j])*PB +: PB];
    end

    assign occ_base = occ - 2'(pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1       <= 1'b0;
            p1_pad   <= '0;
            p1_bank  <= '{default: '0};
            p1_first <= 1'b0;
            p1_last  <= 1'b0;
            e_data   <= '{default: '0};
            e_first  <= '0;
            e_last   <= '0;
            occ      <= '0;
        end else begin
            v1       <= issue;
            p1_pad   <= lane_pad;
            p1_bank  <= lane_bank;
            p1_first <= col_is_first;
            p1_last  <= col_is_last;
            if (pop) begin
                e_data[0]  <= e_data[1];
                e_first[0] <= e_first[1];
                e_last[0]  <= e_last[1];
            end
            // A push into slot 0 overrides the shift above when the FIFO drains this cycle
            if (v1) begin
                if (occ_base == 2'd0) begin
                    e_data[0]  <= din_data;
                    e_first[0] <= p1_first;
                    e_last[0]  <= p1_last;
                end else begin
                    e_data[1]  <= din_data;
                    e_first[1] <= p1_first;
                    e_last[1]  <= p1_last;
                end
            end
            occ <= occ_base + 2'(v1);
        end
    end

    assign col_valid = (occ != 2'd0);
    assign col_data  = e_data[0];
    assign col_first = e_first[0];
    assign col_last  = e_last[0];

endmodule

// File: tb/tb_conv_win_seq.sv
// tb/tb_conv_win_seq.sv - directed self-checking bench for conv_win_seq
module tb_conv_win_seq;
    localparam int XB = 10;
    localparam int YB = 10;
    localparam int PB = 8;
    localparam int NM = 4;
    localparam int K  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [XB-1:0]     cfg_width;
    logic [YB-1:0]     cfg_height;
    logic              cfg_pad_mode;
    logic              start;
    logic [NM-1:0]     mb_minfill;
    logic [NM*PB-1:0]  pu_data;
    logic [NM-1:0]     mb_rd_en;
    logic [XB-1:0]     mb_rd_addr;
    logic [NM-1:0]     mem_release;
    logic [K*PB-1:0]   col_data;
    logic              col_valid;
    logic              col_first;
    logic              col_last;
    logic              pu_ready;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    logic [K*PB-1:0] got_data [$];
    bit              got_first [$];
    bit              got_last [$];
    int              got_cyc [$];
    logic [NM-1:0]   rel_q [$];
    int              done_cyc;
    int              stall_chg;

    conv_win_seq #(.XB(XB), .YB(YB), .PB(PB), .NM(NM), .K(K)) dut (
        .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_pad_mode(cfg_pad_mode), .start(start), .mb_minfill(mb_minfill),
        .pu_data(pu_data), .mb_rd_en(mb_rd_en), .mb_rd_addr(mb_rd_addr),
        .mem_release(mem_release), .col_data(col_data), .col_valid(col_valid),
        .col_first(col_first), .col_last(col_last), .pu_ready(pu_ready),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Bank b holds source row b; pixel(row,col) = 16*row + col, unread banks return 0xAA
    always @(posedge clk) begin
        for (int b = 0; b < NM; b++)
            pu_data[b*PB +: PB] <= mb_rd_en[b] ? 8'(16 * b + int'(mb_rd_addr)) : 8'hAA;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [K*PB-1:0] pk(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [K*PB-1:0] model_col(input bit clamp, input int w, input int ht,
                                                  input int r, input int c);
        logic [K*PB-1:0] v;
        int s;
        int x;
        v = '0;
        for (int j = 0; j < K; j++) begin
            s = r - 1 + j;
            x = c - 1;
            if (clamp) begin
                s = (s < 0) ? 0 : ((s > ht - 1) ? ht - 1 : s);
                x = (x < 0) ? 0 : ((x > w - 1) ? w - 1 : x);
                v[j*PB +: PB] = 8'(16 * s + x);
            end else if (s >= 0 && s < ht && x >= 0 && x < w) begin
                v[j*PB +: PB] = 8'(16 * s + x);
            end
        end
        return v;
    endfunction

    task automatic run_frame(input bit pad, input int w, input int ht, input bit toggle,
                             input int max_cyc);
        bit held;
        logic [K*PB-1:0] hd;
        bit hf;
        bit hl;
        got_data.delete();
        got_first.delete();
        got_last.delete();
        got_cyc.delete();
        rel_q.delete();
        done_cyc  = -1;
        stall_chg = 0;
        held      = 1'b0;
        cfg_width    = XB'(w);
        cfg_height   = YB'(ht);
        cfg_pad_mode = pad;
        pu_ready     = 1'b1;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < max_cyc && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (held && (!col_valid || col_data !== hd || col_first !== hf || col_last !== hl))
                stall_chg++;
            held = col_valid && !pu_ready;
            hd = col_data;
            hf = col_first;
            hl = col_last;
            if (col_valid && pu_ready) begin
                got_data.push_back(col_data);
                got_first.push_back(col_first);
                got_last.push_back(col_last);
                got_cyc.push_back(cyc);
            end
            if (mem_release != '0)
                rel_q.push_back(mem_release);
            if (frame_done)
                done_cyc = cyc;
            @(posedge clk); #1;
            if (toggle)
                pu_ready = !pu_ready;
        end
        pu_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b1;
        cfg_width = 4;
        cfg_height = 3;
        cfg_pad_mode = 1'b0;
        pu_ready = 1'b1;
        mb_minfill = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mb_rd_en, mb_rd_addr, mem_release, col_data, col_valid, col_first, col_last,
             frame_done, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_en=%b addr=%0d rel=%b data=%h v=%b f=%b l=%b done=%b err=%b, want all 0",
                     mb_rd_en, mb_rd_addr, mem_release, col_data, col_valid, col_first, col_last,
                     frame_done, cfg_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, want 0", busy);
        end
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || col_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b col_valid=%b, want 0 0", busy, col_valid);
        end
    endtask

    task automatic test_basic;
        int n;
        run_frame(1'b0, 4, 3, 1'b0, 300);
        n = got_data.size();
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL basic_count: got %0d, want 18", n);
        end
        if (n >= 6) begin
            checks++;
            if (got_data[1] !== pk(0, 0, 16)) begin
                errors++;
                $display("FAIL basic_r0c1: got %h, want %h", got_data[1], pk(0, 0, 16));
            end
            checks++;
            if (got_data[5] !== '0) begin
                errors++;
                $display("FAIL basic_r0c5: got %h, want 000000", got_data[5]);
            end
        end
        for (int i = 0; i < n && i < 18; i++) begin
            checks++;
            if (got_data[i] !== model_col(1'b0, 4, 3, i / 6, i % 6) ||
                got_first[i] !== (i % 6 == 0) || got_last[i] !== (i % 6 == 5)) begin
                errors++;
                $display("FAIL basic_col%0d: got %h f=%b l=%b, want %h f=%b l=%b", i, got_data[i],
                         got_first[i], got_last[i], model_col(1'b0, 4, 3, i / 6, i % 6),
                         (i % 6 == 0), (i % 6 == 5));
            end
            if (i + 1 < n && !got_last[i]) begin
                checks++;
                if (got_cyc[i+1] - got_cyc[i] != 1) begin
                    errors++;
                    $display("FAIL basic_rate%0d: got gap %0d, want 1", i, got_cyc[i+1] - got_cyc[i]);
                end
            end
        end
        checks++;
        if (rel_q.size() != 2 || rel_q[0] !== 4'b0001 || rel_q[1] !== 4'b0110) begin
            errors++;
            $display("FAIL basic_release: got %0d pulses first=%b second=%b, want 2 pulses 0001 0110",
                     rel_q.size(), (rel_q.size() > 0) ? rel_q[0] : 4'hF,
                     (rel_q.size() > 1) ? rel_q[1] : 4'hF);
        end
        checks++;
        if (n == 0 || done_cyc != got_cyc[n-1] + 1) begin
            errors++;
            $display("FAIL basic_frame_done: got cycle %0d, want %0d", done_cyc,
                     (n > 0) ? got_cyc[n-1] + 1 : -99);
        end
    endtask

    task automatic test_clamp;
        int n;
        run_frame(1'b1, 4, 3, 1'b0, 300);
        n = got_data.size();
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL clamp_count: got %0d, want 18", n);
        end
        if (n == 18) begin
            checks++;
            if (got_data[0] !== pk(0, 0, 16)) begin
                errors++;
                $display("FAIL clamp_r0c0: got %h, want %h", got_data[0], pk(0, 0, 16));
            end
            checks++;
            if (got_data[17] !== pk(19, 35, 35)) begin
                errors++;
                $display("FAIL clamp_r2c5: got %h, want %h", got_data[17], pk(19, 35, 35));
            end
        end
        for (int i = 0; i < n && i < 18; i++) begin
            checks++;
            if (got_data[i] !== model_col(1'b1, 4, 3, i / 6, i % 6)) begin
                errors++;
                $display("FAIL clamp_col%0d: got %h, want %h", i, got_data[i],
                         model_col(1'b1, 4, 3, i / 6, i % 6));
            end
        end
    endtask

    task automatic test_backpressure;
        int n;
        run_frame(1'b0, 4, 3, 1'b1, 400);
        n = got_data.size();
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL bp_count: got %0d, want 18", n);
        end
        for (int i = 0; i < n && i < 18; i++) begin
            checks++;
            if (got_data[i] !== model_col(1'b0, 4, 3, i / 6, i % 6) ||
                got_first[i] !== (i % 6 == 0) || got_last[i] !== (i % 6 == 5)) begin
                errors++;
                $display("FAIL bp_col%0d: got %h f=%b l=%b, want %h", i, got_data[i],
                         got_first[i], got_last[i], model_col(1'b0, 4, 3, i / 6, i % 6));
            end
        end
        checks++;
        if (stall_chg != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d changes while stalled, want 0", stall_chg);
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL bp_frame_done: got none, want pulse");
        end
    endtask

    task automatic test_minfill;
        int acc;
        int rd_late;
        bit done_seen;
        mb_minfill = 4'b1011;
        cfg_width = 4;
        cfg_height = 3;
        cfg_pad_mode = 1'b1;
        pu_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0;
        rd_late = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_valid && pu_ready)
                acc++;
            if (i >= 20 && mb_rd_en != '0)
                rd_late++;
            @(posedge clk); #1;
        end
        checks++;
        if (acc != 6 || rd_late != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL minfill_hold: got cols=%0d late_reads=%0d busy=%b, want 6 0 1", acc, rd_late, busy);
        end
        mb_minfill = 4'b1111;
        checks++;
        if (mb_rd_en !== 4'b0000) begin
            errors++;
            $display("FAIL minfill_same_cycle: got rd_en=%b, want 0000", mb_rd_en);
        end
        @(posedge clk); #1;
        checks++;
        if (mb_rd_en !== 4'b0111 || mb_rd_addr !== '0) begin
            errors++;
            $display("FAIL minfill_resume: got rd_en=%b addr=%0d, want 0111 0", mb_rd_en, mb_rd_addr);
        end
        acc = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            @(negedge clk);
            if (col_valid && pu_ready)
                acc++;
            if (frame_done)
                done_seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (acc != 12 || !done_seen) begin
            errors++;
            $display("FAIL minfill_finish: got cols=%0d done=%b, want 12 1", acc, done_seen);
        end
    endtask

    task automatic test_narrow;
        int n;
        mb_minfill = 4'b0011;
        run_frame(1'b0, 1, 2, 1'b0, 200);
        mb_minfill = 4'b1111;
        n = got_data.size();
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL narrow_count: got %0d, want 6", n);
        end
        for (int i = 0; i < n && i < 6; i++) begin
            checks++;
            if (got_data[i] !== model_col(1'b0, 1, 2, i / 3, i % 3) ||
                got_first[i] !== (i % 3 == 0) || got_last[i] !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL narrow_col%0d: got %h f=%b l=%b, want %h f=%b l=%b", i, got_data[i],
                         got_first[i], got_last[i], model_col(1'b0, 1, 2, i / 3, i % 3),
                         (i % 3 == 0), (i % 3 == 2));
            end
        end
        checks++;
        if (rel_q.size() != 1 || rel_q[0] !== 4'b0011) begin
            errors++;
            $display("FAIL narrow_release: got %0d pulses first=%b, want 1 pulse 0011",
                     rel_q.size(), (rel_q.size() > 0) ? rel_q[0] : 4'hF);
        end
    endtask

    task automatic test_cfg_err_reset;
        int acc;
        cfg_width = 0;
        cfg_height = 3;
        cfg_pad_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse: got cfg_err=%b busy=%b, want 1 0", cfg_err, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_width: got %b, want 0", cfg_err);
        end
        cfg_width = 8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0;
        for (int i = 0; i < 200 && acc < 17; i++) begin
            @(negedge clk);
            if (col_valid && pu_ready)
                acc++;
        end
        checks++;
        if (acc != 17) begin
            errors++;
            $display("FAIL midreset_reach: got %0d cols, want 17", acc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (col_valid !== 1'b0 || busy !== 1'b0 || mem_release !== '0 || mb_rd_en !== '0) begin
            errors++;
            $display("FAIL midreset_idle: got valid=%b busy=%b rel=%b rd_en=%b, want 0 0 0000 0000",
                     col_valid, busy, mem_release, mb_rd_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        run_frame(1'b1, 4, 3, 1'b0, 300);
        checks++;
        if (got_data.size() != 18 || got_data[0] !== pk(0, 0, 16) || done_cyc < 0) begin
            errors++;
            $display("FAIL midreset_replay: got %0d cols first=%h done=%0d, want 18 %h done",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : '1, done_cyc, pk(0, 0, 16));
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        cfg_pad_mode = 1'b0;
        mb_minfill = '1;
        pu_ready = 1'b1;
        test_reset();
        test_basic();
        test_clamp();
        test_backpressure();
        test_minfill();
        test_narrow();
        test_cfg_err_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
